// File: rtl/prd_freq_div_pkg.sv
// ---------------------------------------------------------------------------
// prd_freq_div_pkg
// Shared definitions for the period-measurement chain: the divider FSM state
// encoding, the default operand width and constant dividend (microseconds per
// second), and the quotient saturation value.
// The period counter and the scaling stage import the same defaults, so all
// three blocks agree on the width of prd and of the frequency result.
// ---------------------------------------------------------------------------
package prd_freq_div_pkg;

    // Divider FSM states. The unused code 2'b11 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } prd_state_t;

    // Default operand/result width; matches the period counter's prd output.
    localparam int PRD_W    = 20;

    // Constant dividend: microseconds per second. It must fit in PRD_W bits.
    localparam int PRD_DVND = 1_000_000;

    // All-ones quotient. Reported on divide-by-zero and used as the rounding
    // saturation limit.
    localparam logic [PRD_W-1:0] PRD_QUO_SAT = {PRD_W{1'b1}};

endpackage : prd_freq_div_pkg

// File: rtl/prd_div_step.sv
// ---------------------------------------------------------------------------
// prd_div_step
// Combinational leaf that performs one restoring-division iteration. It
// shifts the next dividend bit into the partial remainder, compares against
// the divisor, and subtracts when the divisor fits.
// Ports:
//   i_r      W-bit partial remainder from the previous iteration
//   i_msb    dividend bit shifted in on this iteration
//   i_dvsr   W-bit divisor
//   o_r_next W-bit partial remainder after this iteration
//   o_q_bit  quotient bit produced on this iteration
// ---------------------------------------------------------------------------
module prd_div_step #(
    parameter int W = 20
) (
    input  logic [W-1:0] i_r,
    input  logic         i_msb,
    input  logic [W-1:0] i_dvsr,
    output logic [W-1:0] o_r_next,
    output logic         o_q_bit
);

    // The shifted remainder needs one extra bit before the compare.
    logic [W:0] w_r_shift;

    assign w_r_shift = {i_r, i_msb};

    // Compare/subtract. When the divisor fits, the true difference is below
    // the divisor, so it is representable in W bits. The low W bits of the
    // subtraction are therefore exact.
    always_comb begin
        if (w_r_shift >= {1'b0, i_dvsr}) begin
            o_r_next = w_r_shift[W-1:0] - i_dvsr;
            o_q_bit  = 1'b1;
        end else begin
            o_r_next = w_r_shift[W-1:0];
            o_q_bit  = 1'b0;
        end
    end

endmodule : prd_div_step

// File: rtl/prd_freq_div.sv
// ---------------------------------------------------------------------------
// prd_freq_div
// Sequential restoring divider that converts a measured period in
// microseconds into a frequency in Hz: quo = DVND / dvsr.
// It produces one quotient bit per clock, MSB first. Its handshake matches
// the period counter, so the counter's done_tick can drive start directly.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      launch a division; only sampled while ready=1
//   dvsr       W-bit divisor (period in us), captured when start is accepted
//   ready      high while idle
//   done_tick  one-cycle pulse when quo/rmd/div0 become valid
//   quo        W-bit quotient (frequency in Hz)
//   rmd        W-bit remainder
//   div0       set when the captured divisor was zero
// Optional build macro: PRD_FREQ_DIV_ROUND_EN
//   When defined, the quotient is rounded to nearest on the final iteration.
//   Rounding saturates at all ones. rmd still reports the truncated
//   remainder, and rounding is not applied on the divide-by-zero path.
// ---------------------------------------------------------------------------
module prd_freq_div
    import prd_freq_div_pkg::*;
#(
    parameter int W    = PRD_W,
    parameter int DVND = PRD_DVND
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dvsr,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] quo,
    output logic [W-1:0] rmd,
    output logic         div0
);

    localparam int           NW        = $clog2(W + 1);
    localparam logic [W-1:0] L_DVND    = W'(DVND);
    localparam logic [W-1:0] L_QUO_SAT = {W{1'b1}};

    prd_state_t    r_state;
    logic [W-1:0]  r_dvsr;
    logic [W-1:0]  r_dvnd;      // dividend, shifting left; quotient bits fill from LSB
    logic [W-1:0]  r_rem;
    logic [NW-1:0] r_n;
    logic          r_done_tick;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rmd;
    logic          r_div0;

    logic [W-1:0]  w_r_next;
    logic          w_q_bit;
    logic [W-1:0]  w_q_final;
    logic [W-1:0]  w_quo_final;

    prd_div_step #(
        .W (W)
    ) u_step (
        .i_r      (r_rem),
        .i_msb    (r_dvnd[W-1]),
        .i_dvsr   (r_dvsr),
        .o_r_next (w_r_next),
        .o_q_bit  (w_q_bit)
    );

    // Quotient as it stands after the current op iteration, with optional
    // round-to-nearest applied. This value is used only on the final iteration.
    always_comb begin
        w_q_final   = {r_dvnd[W-2:0], w_q_bit};
        w_quo_final = w_q_final;
`ifdef PRD_FREQ_DIV_ROUND_EN
        // Round up when the remainder is at least half the divisor:
        // 2*r >= d. The doubled remainder needs W+1 bits.
        if (({w_r_next, 1'b0} >= {1'b0, r_dvsr}) && (w_q_final != L_QUO_SAT)) begin
            w_quo_final = w_q_final + {{(W-1){1'b0}}, 1'b1};
        end else begin
            w_quo_final = w_q_final;
        end
`else
        w_quo_final = w_q_final;
`endif
    end

    // Divider FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dvsr      <= '0;
            r_dvnd      <= '0;
            r_rem       <= '0;
            r_n         <= '0;
            r_done_tick <= 1'b0;
            r_quo       <= '0;
            r_rmd       <= '0;
            r_div0      <= 1'b0;
        end else begin
            r_done_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvsr <= dvsr;
                        r_dvnd <= L_DVND;
                        r_rem  <= '0;
                        r_n    <= NW'(W);
                        if (dvsr == '0) begin
                            // Skip the iterations and report saturation directly.
                            r_state     <= DONE;
                            r_done_tick <= 1'b1;
                            r_quo       <= L_QUO_SAT;
                            r_rmd       <= L_DVND;
                            r_div0      <= 1'b1;
                        end else begin
                            r_state <= OP;
                            r_div0  <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OP: begin
                    r_rem  <= w_r_next;
                    r_dvnd <= {r_dvnd[W-2:0], w_q_bit};
                    r_n    <= r_n - NW'(1);
                    if (r_n == NW'(1)) begin
                        r_state     <= DONE;
                        r_done_tick <= 1'b1;
                        r_quo       <= w_quo_final;
                        r_rmd       <= w_r_next;
                    end else begin
                        r_state <= OP;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == IDLE);
    assign done_tick = r_done_tick;
    assign quo       = r_quo;
    assign rmd       = r_rmd;
    assign div0      = r_div0;

endmodule : prd_freq_div

// File: tb/tb_prd_freq_div.sv
// ---------------------------------------------------------------------------
// tb_prd_freq_div
// Directed self-checking bench for prd_freq_div with hand-computed quotients
// of 1_000_000 / dvsr. Inputs are driven and outputs sampled on the falling
// edge. Cycle 0 is the cycle in which start is presented to the idle divider.
// ---------------------------------------------------------------------------
module tb_prd_freq_div;
    import prd_freq_div_pkg::*;

    localparam int W = PRD_W;

`ifdef PRD_FREQ_DIV_ROUND_EN
    localparam logic [31:0] EXP_Q6   = 32'd166667;
    localparam logic [31:0] EXP_QBIG = 32'd1;
`else
    localparam logic [31:0] EXP_Q6   = 32'd166666;
    localparam logic [31:0] EXP_QBIG = 32'd0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dvsr;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] quo;
    logic [W-1:0] rmd;
    logic         div0;

    int n_checks = 0;
    int n_fail   = 0;

    prd_freq_div dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dvsr      (dvsr),
        .ready     (ready),
        .done_tick (done_tick),
        .quo       (quo),
        .rmd       (rmd),
        .div0      (div0)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present start for one cycle, then count cycles until done_tick (bounded).
    task automatic run_div(input logic [W-1:0] d, output int cyc);
        @(negedge clk);
        start = 1'b1;
        dvsr  = d;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done_tick && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_case(input string tag, input logic [W-1:0] d,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic [31:0] ed0, input logic [31:0] ecyc);
        int cyc;
        run_div(d, cyc);
        check_val({tag, "_lat"},  32'(cyc), ecyc);
        check_val({tag, "_quo"},  32'(quo), eq);
        check_val({tag, "_rmd"},  32'(rmd), er);
        check_val({tag, "_div0"}, 32'(div0), ed0);
        @(negedge clk);
        check_val({tag, "_tick_1cyc"}, 32'(done_tick), 32'd0);
        check_val({tag, "_ready"},     32'(ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int cyc2;
        int seen;

        reset = 1'b1;
        start = 1'b0;
        dvsr  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_tick",  32'(done_tick), 32'd0);
        check_val("rst_quo",   32'(quo), 32'd0);
        check_val("rst_rmd",   32'(rmd), 32'd0);
        check_val("rst_div0",  32'(div0), 32'd0);

        do_case("d1",   20'd1,       32'd1000000, 32'd0,       32'd0, 32'd21);
        do_case("d7",   20'd7,       32'd142857,  32'd1,       32'd0, 32'd21);
        do_case("d6",   20'd6,       EXP_Q6,      32'd4,       32'd0, 32'd21);
        do_case("dbig", 20'd1048575, EXP_QBIG,    32'd1000000, 32'd0, 32'd21);
        do_case("d0",   20'd0,       32'(PRD_QUO_SAT), 32'd1000000, 32'd1, 32'd1);
        do_case("d3",   20'd3,       32'd333333,  32'd1,       32'd0, 32'd21);
        do_case("d2000", 20'd2000,   32'd500,     32'd0,       32'd0, 32'd21);

        // start pulse and divisor change during op must be ignored
        @(negedge clk);
        start = 1'b1;
        dvsr  = 20'd7;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        repeat (2) begin @(negedge clk); cyc++; end
        start = 1'b1;
        dvsr  = 20'd5;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        dvsr  = 20'd0;
        while (!done_tick && cyc < 100) begin @(negedge clk); cyc++; end
        check_val("ign_lat",  32'(cyc), 32'd21);
        check_val("ign_quo",  32'(quo), 32'd142857);
        check_val("ign_rmd",  32'(rmd), 32'd1);
        check_val("ign_div0", 32'(div0), 32'd0);
        @(negedge clk);

        // start held high: back-to-back divisions every W+2 cycles
        start = 1'b1;
        dvsr  = 20'd1;
        @(negedge clk);
        cyc = 1;
        while (!done_tick && cyc < 100) begin @(negedge clk); cyc++; end
        check_val("b2b_lat1", 32'(cyc), 32'd21);
        @(negedge clk);
        cyc2 = 1;
        while (!done_tick && cyc2 < 100) begin @(negedge clk); cyc2++; end
        start = 1'b0;
        check_val("b2b_period", 32'(cyc2), 32'd22);
        check_val("b2b_quo",    32'(quo), 32'd1000000);
        @(negedge clk);

        // reset at cycle 10 of op: abort, outputs cleared, no done_tick
        start = 1'b1;
        dvsr  = 20'd7;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mid_rst_ready", 32'(ready), 32'd1);
        check_val("mid_rst_quo",   32'(quo), 32'd0);
        check_val("mid_rst_rmd",   32'(rmd), 32'd0);
        check_val("mid_rst_div0",  32'(div0), 32'd0);
        seen = 0;
        repeat (30) begin
            if (done_tick) seen++;
            @(negedge clk);
        end
        check_val("mid_rst_no_tick", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prd_freq_div
